// File: rtl/encoder8x3_stream.sv
// Streams the index of every set bit of an accepted 8-bit request vector over a valid/ready port.
// Build option: define ENC_MSB_FIRST_EN to emit the highest set bit first instead of the lowest.
module encoder8x3_stream (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_in,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [2:0] idx_out,
    output logic       idx_valid,
    input  logic       idx_ready,
    output logic       idx_last,
    output logic [3:0] pend_cnt,
    output logic       zero_req
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [3:0] cnt_q, cnt_d;
    logic       zero_q, zero_d;
    logic       live_q;
    logic [2:0] sel;
    logic [3:0] req_pop;

    // Scan in reverse priority so the last hit wins.
    always_comb begin
        sel = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int unsigned i = 0; i < 8; i++) begin
            if (pending_q[i]) sel = 3'(i);
        end
`else
        for (int unsigned i = 8; i > 0; i--) begin
            if (pending_q[i-1]) sel = 3'(i - 1);
        end
`endif
    end

    always_comb begin
        req_pop = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            req_pop = req_pop + 4'(req_in[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        zero_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && live_q) begin
                    if (req_in != '0) begin
                        pending_d = req_in;
                        cnt_d     = req_pop;
                        state_d   = EMIT;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (idx_ready) begin
                    pending_d = pending_q & ~(8'b1 << sel);
                    cnt_d     = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // live_q keeps req_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
            zero_q    <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            zero_q    <= zero_d;
            live_q    <= 1'b1;
        end
    end

    assign req_ready = live_q && (state_q == IDLE);
    assign idx_valid = (state_q == EMIT);
    assign idx_out   = idx_valid ? sel : '0;
    assign idx_last  = idx_valid && (cnt_q == 4'd1);
    assign pend_cnt  = cnt_q;
    assign zero_req  = zero_q;

endmodule

// File: tb/tb_encoder8x3_stream.sv
// Directed and randomized checks of encoder8x3_stream against a set-bit-list reference model.
module tb_encoder8x3_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] idx_out;
    logic       idx_valid;
    logic       idx_ready;
    logic       idx_last;
    logic [3:0] pend_cnt;
    logic       zero_req;

    int total = 0;
    int bad   = 0;

    encoder8x3_stream dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx_last  (idx_last),
        .pend_cnt  (pend_cnt),
        .zero_req  (zero_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the list of set-bit positions in emission order.
    task automatic order_of(input logic [7:0] vec, output int q[$]);
        q = {};
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
`ifdef ENC_MSB_FIRST_EN
                q.push_front(i);
`else
                q.push_back(i);
`endif
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        if (req_ready !== 1'b1) chk("ready_timeout", {31'd0, req_ready}, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rdy"}, {31'd0, req_ready}, 1);
        chk({tag, "_vld"}, {31'd0, idx_valid}, 0);
        chk({tag, "_idx"}, {29'd0, idx_out}, 0);
        chk({tag, "_last"}, {31'd0, idx_last}, 0);
        chk({tag, "_cnt"}, {28'd0, pend_cnt}, 0);
    endtask

    // stall_mode: 0 none, 1 three-cycle stall on the first index, 2 random stalls
    task automatic send_vec(input logic [7:0] vec, input int stall_mode);
        int q[$];
        int k;
        int stalls;
        order_of(vec, q);
        k = q.size();
        wait_ready();
        req_in    = vec;
        req_valid = 1'b1;
        idx_ready = 1'(($urandom));
        step();
        req_valid = 1'(($urandom));
        req_in    = 8'($urandom);
        if (k == 0) begin
            req_valid = 1'b0;
            chk("zero_pulse", {31'd0, zero_req}, 1);
            chk("zero_novld", {31'd0, idx_valid}, 0);
            chk("zero_rdy", {31'd0, req_ready}, 1);
            step();
            chk("zero_once", {31'd0, zero_req}, 0);
            chk("zero_novld2", {31'd0, idx_valid}, 0);
            return;
        end
        for (int n = 0; n < k; n++) begin
            stalls = (stall_mode == 1 && n == 0) ? 3 :
                     (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            idx_ready = 1'b0;
            for (int s = 0; s < stalls; s++) begin
                chk("stall_vld", {31'd0, idx_valid}, 1);
                chk("stall_idx", {29'd0, idx_out}, 32'(q[n]));
                chk("stall_last", {31'd0, idx_last}, 32'(n == k - 1));
                chk("stall_cnt", {28'd0, pend_cnt}, 32'(k - n));
                step();
            end
            idx_ready = 1'b1;
            chk("emit_vld", {31'd0, idx_valid}, 1);
            chk("emit_idx", {29'd0, idx_out}, 32'(q[n]));
            chk("emit_last", {31'd0, idx_last}, 32'(n == k - 1));
            chk("emit_cnt", {28'd0, pend_cnt}, 32'(k - n));
            chk("emit_busy", {31'd0, req_ready}, 0);
            chk("emit_nozero", {31'd0, zero_req}, 0);
            step();
            req_valid = (n == k - 1) ? 1'b0 : 1'(($urandom));
            req_in    = 8'($urandom);
        end
        idx_ready = 1'(($urandom));
        check_idle("drained");
    endtask

    initial begin
        int q[$];
        rst       = 1'b1;
        req_valid = 1'b0;
        req_in    = '0;
        idx_ready = 1'b0;
        #2;
        chk("rst_rdy", {31'd0, req_ready}, 0);
        chk("rst_vld", {31'd0, idx_valid}, 0);
        chk("rst_cnt", {28'd0, pend_cnt}, 0);
        chk("rst_zero", {31'd0, zero_req}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_rdy_low", {31'd0, req_ready}, 0);
        step();
        chk("rel_rdy_high", {31'd0, req_ready}, 1);

        send_vec(8'b1010_0100, 0);
        send_vec(8'h81, 1);
        send_vec(8'h00, 0);
        send_vec(8'hFF, 0);
        send_vec(8'h10, 0);

        // Reset mid-drain of 8'h0F after two transfers.
        order_of(8'h0F, q);
        wait_ready();
        req_in    = 8'h0F;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        idx_ready = 1'b1;
        chk("mid_idx0", {29'd0, idx_out}, 32'(q[0]));
        step();
        chk("mid_idx1", {29'd0, idx_out}, 32'(q[1]));
        step();
        chk("mid_vld_pre", {31'd0, idx_valid}, 1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_vld", {31'd0, idx_valid}, 0);
        chk("mid_rst_rdy", {31'd0, req_ready}, 0);
        chk("mid_rst_idx", {29'd0, idx_out}, 0);
        chk("mid_rst_last", {31'd0, idx_last}, 0);
        chk("mid_rst_cnt", {28'd0, pend_cnt}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rel_rdy", {31'd0, req_ready}, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_after_vld", {31'd0, idx_valid}, 0);
            chk("mid_after_rdy", {31'd0, req_ready}, 1);
        end

        for (int r = 0; r < 40; r++) begin
            send_vec(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
